cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling initiator that sits between the cache control logic and the multi-cycle, pipelined data memory. On a cache miss it issues one read per cycle for every 16-bit word of the missing block and streams the returned words into the cache data array. After the last word lands it writes the tag array. It is the requesting end of the same byte-addressed, 16-bit word, even-address memory interface that the memory module serves.

## Interface
- ADDR_WIDTH, 16, byte-address width of miss_address and memory_address
- BLOCK_WORDS, 8, 16-bit words per cache block; must be a power of two ≥ 2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- miss_detected  input  1  cache reports a miss this cycle; sampled only in IDLE
- miss_address  input  ADDR_WIDTH  byte address that missed
- memory_data_valid  input  1  memory_data_in holds a returned read word this cycle
- memory_data_in  input  16  read data from memory
- fsm_busy  output  1  high in FILL and TAG states; cache stalls the pipeline on it
- memory_enable  output  1  read request strobe; memory write-enable is tied low outside this block
- memory_address  output  ADDR_WIDTH  request byte address, bit 0 always 0
- write_data_array  output  1  write cache_data_out into word cache_word_index of the block being filled
- cache_word_index  output  log2(BLOCK_WORDS)  destination word within the block
- cache_data_out  output  16  combinational pass-through of memory_data_in
- write_tag_array  output  1  one-cycle tag/valid write for the filled block
- fill_done  output  1  one-cycle pulse, coincident with write_tag_array

## Operation
- States: IDLE, FILL, TAG.
- The block base is miss_address with its low log2(BLOCK_WORDS)+1 bits cleared. It is latched when IDLE samples miss_detected=1.
- IDLE: fsm_busy=0, no strobes. If miss_detected=1: latch base, clear issue_cnt and recv_cnt, go to FILL.
- FILL: fsm_busy=1.
  - Request side: memory_enable=1 while issue_cnt < BLOCK_WORDS. memory_address = base + 2*issue_cnt. issue_cnt increments each cycle memory_enable=1. After the last request, memory_enable=0 and memory_address is held at the last value.
  - Return side: each cycle memory_data_valid=1 and recv_cnt < BLOCK_WORDS, drive write_data_array=1 with cache_word_index=recv_cnt, then increment recv_cnt.
  - When a valid arrives with recv_cnt = BLOCK_WORDS-1, go to TAG.
- TAG: write_tag_array=1, fill_done=1, fsm_busy=1 for exactly one cycle, then go to IDLE.
- Request and return counters are independent. Issuing and receiving may overlap in the same cycle.
- Address arithmetic is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH. Block alignment guarantees no carry out of the block, so base 0xFFF0 yields requests 0xFFF0..0xFFFE.

## Timing
- Reset: state=IDLE, counters=0, base=0. All outputs are 0 during and after reset, except cache_data_out, which follows memory_data_in.
- Reset mid-fill aborts immediately: the next cycle is IDLE with no further strobes. Later stray memory_data_valid pulses are ignored.
- miss_detected high in cycle 0 gives FILL in cycle 1. Requests go out in cycles 1..BLOCK_WORDS.
- With the standard 4-cycle memory and BLOCK_WORDS=8: data valid in cycles 5..12, TAG in cycle 13, IDLE in cycle 14. Miss-to-fill_done is 13 cycles.
- Memory latency is not hard-coded. Completion is driven only by the count of memory_data_valid pulses, so any fixed latency ≥ 1 works.
- memory_data_valid in IDLE or TAG is ignored. miss_detected during FILL or TAG is ignored; the cache re-asserts it after the fill if it still misses.
- A miss asserted in the IDLE cycle right after TAG starts a new fill. There is no mandatory dead cycle beyond that IDLE cycle.

## Test plan
- Basic fill: miss_address=0x1236, 4-cycle memory returning mem[a]=a^0xA5A5 -> requests 0x1230,0x1232,…,0x123E in cycles 1–8; write_data_array cycles 5–12 with index 0..7 and data 0xB795… matching; write_tag_array=fill_done=1 only in cycle 13.
- Wrap/alignment: miss_address=0xFFFF -> base 0xFFF0, last request 0xFFFE, no request to 0x0000.
- Latency sweep: memory latency 1 and 7 -> eight data writes in order; fill_done exactly one cycle after the eighth valid.
- Reset mid-fill: assert rst in cycle 4 of a fill and keep memory returning valids -> from cycle 5 all strobes are 0, fsm_busy=0, no tag write; a fresh miss afterwards completes normally.
- Spurious inputs: memory_data_valid pulses in IDLE, and miss_detected held high throughout a fill -> no data writes in IDLE; a single fill completes with exactly 8 data writes and 1 tag write; a second fill starts from the IDLE cycle after TAG.
- Back-to-back misses to 0x0040 then 0x2000 -> two complete, non-interleaved request sequences; each gets its own fill_done pulse.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss-handling initiator between the cache controller and a pipelined data
// memory. When IDLE sees a miss it latches the block base address and enters
// FILL. FILL has two independent halves:
//   - a request stream that issues one read per cycle for every 16-bit word
//     of the block
//   - a return stream that writes each returned word into the data array
// After the last word lands, a single TAG cycle writes the tag/valid array.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   miss_detected       cache miss indication, sampled only in IDLE
//   miss_address        byte address that missed
//   memory_data_valid   memory_data_in carries a returned word this cycle
//   memory_data_in      read data from memory
//   fsm_busy            high in FILL and TAG (registered)
//   memory_enable       read request strobe (registered)
//   memory_address      request byte address, bit 0 always 0 (registered)
//   write_data_array    write cache_data_out into word cache_word_index
//   cache_word_index    destination word within the block
//   cache_data_out      combinational pass-through of memory_data_in
//   write_tag_array     one-cycle tag/valid write (registered)
//   fill_done           one-cycle completion pulse, same cycle as tag write
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8,
  localparam int IDX_W      = $clog2(BLOCK_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data_in,
  output logic                  fsm_busy,
  output logic                  memory_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [IDX_W-1:0]      cache_word_index,
  output logic [15:0]           cache_data_out,
  output logic                  write_tag_array,
  output logic                  fill_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  // A block spans BLOCK_WORDS * 2 bytes, so the low IDX_W+1 address bits
  // select the byte within the block and are cleared to form the base.
  localparam logic [ADDR_WIDTH-1:0] BLOCK_OFFSET_MASK =
    ADDR_WIDTH'((2 * BLOCK_WORDS) - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(BLOCK_WORDS - 1);

  state_t                  state;
  logic [IDX_W-1:0]        issue_cnt;   // word index currently on the request bus
  logic [IDX_W-1:0]        recv_cnt;    // words already written into the block
  logic [ADDR_WIDTH-1:0]   base;

  logic [ADDR_WIDTH-1:0]   miss_base;
  logic [IDX_W-1:0]        issue_inc;
  logic [ADDR_WIDTH-1:0]   next_req_addr;
  logic                    last_issue;
  logic                    last_recv;
  logic                    take_word;

  assign miss_base  = miss_address & ~BLOCK_OFFSET_MASK;
  assign issue_inc  = issue_cnt + IDX_W'(1);
  assign last_issue = (issue_cnt == LAST_WORD);
  assign last_recv  = (recv_cnt == LAST_WORD);

  // The base is block aligned, so the word offset can be OR-ed into the
  // cleared low bits; no carry can ever leave the block.
  assign next_req_addr = base | {{(ADDR_WIDTH-IDX_W-1){1'b0}}, issue_inc, 1'b0};

  // Returned words are written in the same cycle they arrive, so the write
  // strobe is decoded combinationally from the registered state. Reset
  // suppresses it so an aborted fill never writes during the reset cycle.
  assign take_word        = (state == FILL) && memory_data_valid && !rst;
  assign write_data_array = take_word;
  assign cache_word_index = recv_cnt;
  assign cache_data_out   = memory_data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      issue_cnt       <= '0;
      recv_cnt        <= '0;
      base            <= '0;
      fsm_busy        <= 1'b0;
      memory_enable   <= 1'b0;
      memory_address  <= '0;
      write_tag_array <= 1'b0;
      fill_done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          write_tag_array <= 1'b0;
          fill_done       <= 1'b0;
          if (miss_detected) begin
            // The first request goes out in the first FILL cycle, so it is
            // registered here together with the state change.
            base           <= miss_base;
            issue_cnt      <= '0;
            recv_cnt       <= '0;
            memory_enable  <= 1'b1;
            memory_address <= miss_base;
            fsm_busy       <= 1'b1;
            state          <= FILL;
          end
        end

        FILL: begin
          // Request side: step through the block one word per cycle and
          // hold the last address once every word has been requested.
          if (memory_enable) begin
            if (last_issue) begin
              memory_enable <= 1'b0;
            end else begin
              issue_cnt      <= issue_inc;
              memory_address <= next_req_addr;
            end
          end

          // Return side: completion depends only on the number of valid
          // pulses, never on a latency assumption.
          if (memory_data_valid) begin
            recv_cnt <= recv_cnt + IDX_W'(1);
            if (last_recv) begin
              memory_enable   <= 1'b0;
              write_tag_array <= 1'b1;
              fill_done       <= 1'b1;
              state           <= TAG;
            end
          end
        end

        TAG: begin
          write_tag_array <= 1'b0;
          fill_done       <= 1'b0;
          fsm_busy        <= 1'b0;
          state           <= IDLE;
        end

        default: begin
          memory_enable   <= 1'b0;
          write_tag_array <= 1'b0;
          fill_done       <= 1'b0;
          fsm_busy        <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
//
// Drives cache_fill_fsm against a behavioural memory with configurable read
// latency (response data = address ^ 0xA5A5). A cycle-accounting reference
// model predicts, from the miss cycle and the count of returned words, which
// cycles must carry requests, data writes and the tag write.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;

  localparam int AW = 16;
  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data_in = '0;
  logic        fsm_busy;
  logic        memory_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  cache_word_index;
  logic [15:0] cache_data_out;
  logic        write_tag_array;
  logic        fill_done;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .fsm_busy          (fsm_busy),
    .memory_enable     (memory_enable),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .cache_word_index  (cache_word_index),
    .cache_data_out    (cache_data_out),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // stimulus commands
  logic        rst_cmd  = 1'b1;
  logic        miss_cmd = 1'b0;
  logic [15:0] miss_addr_cmd = '0;
  int          lat      = 4;
  bit          spur_en  = 1'b0;

  // memory response slots, indexed by cycle modulo 16
  bit          slot_v [16];
  logic [15:0] slot_d [16];

  // reference model
  bit          m_active   = 1'b0;
  int          m_start    = 0;
  int          m_writes   = 0;
  int          m_tag_cyc  = -100;
  logic [15:0] m_base     = '0;
  logic [15:0] m_last_addr = '0;

  int tags_seen    = 0;
  int last_tag_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    int          k;
    int          off;
    bit          e_en, e_wr, e_tag, e_busy;
    logic [15:0] e_addr;
    logic [15:0] e_data;
    @(posedge clk);
    #1;
    cyc++;
    rst           = rst_cmd;
    miss_detected = miss_cmd;
    miss_address  = miss_addr_cmd;
    k = cyc % 16;
    if (slot_v[k]) begin
      memory_data_valid = 1'b1;
      memory_data_in    = slot_d[k];
      slot_v[k]         = 1'b0;
    end else if (spur_en && !m_active && ($urandom_range(0, 2) == 0)) begin
      memory_data_valid = 1'b1;
      memory_data_in    = 16'($urandom);
    end else begin
      memory_data_valid = 1'b0;
      memory_data_in    = 16'($urandom);
    end
    #1;
    e_addr = m_last_addr;
    if (!rst) begin
      off    = cyc - m_start;
      e_tag  = (cyc == m_tag_cyc);
      e_busy = m_active || e_tag;
      e_en   = m_active && (off < BW);
      if (m_active) e_addr = m_base + 16'(2 * ((off < BW) ? off : BW - 1));
      e_wr   = m_active && memory_data_valid;
      check("busy",      fsm_busy,         e_busy);
      check("mem_en",    memory_enable,    e_en);
      check("mem_addr",  memory_address,   e_addr);
      check("wr_data",   write_data_array, e_wr);
      check("wr_tag",    write_tag_array,  e_tag);
      check("fill_done", fill_done,        e_tag);
      check("data_pass", cache_data_out,   memory_data_in);
      if (e_wr) begin
        e_data = (m_base + 16'(2 * m_writes)) ^ 16'hA5A5;
        check("word_idx",  cache_word_index, m_writes);
        check("word_data", cache_data_out,   e_data);
      end
      if (fill_done === 1'b1) begin
        tags_seen++;
        last_tag_cyc = cyc;
      end
    end
    // the memory answers every request after the current latency
    if (memory_enable === 1'b1) begin
      slot_v[(cyc + lat) % 16] = 1'b1;
      slot_d[(cyc + lat) % 16] = memory_address ^ 16'hA5A5;
    end
    // advance the reference model with this cycle's inputs
    if (rst) begin
      m_active    = 1'b0;
      m_tag_cyc   = -100;
      m_last_addr = '0;
      m_writes    = 0;
    end else if (m_active) begin
      m_last_addr = e_addr;
      if (memory_data_valid) begin
        m_writes++;
        if (m_writes == BW) begin
          m_active  = 1'b0;
          m_tag_cyc = cyc + 1;
        end
      end
    end else if (cyc != m_tag_cyc && miss_detected) begin
      m_active = 1'b1;
      m_start  = cyc + 1;
      m_base   = miss_address & 16'hFFF0;
      m_writes = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic start_miss(input logic [15:0] a, input int hold, output int c0);
    miss_addr_cmd = a;
    miss_cmd      = 1'b1;
    step();
    c0 = cyc;
    repeat (hold - 1) step();
    miss_cmd = 1'b0;
  endtask

  task automatic single_fill(input string tag, input logic [15:0] a, input int latency);
    int t;
    int c0;
    lat = latency;
    t   = tags_seen;
    start_miss(a, 1, c0);
    idle(BW + latency + 4);
    check({tag, "_tags"}, tags_seen - t, 1);
    check({tag, "_done_cyc"}, last_tag_cyc - c0, BW + latency + 1);
  endtask

  initial begin
    int t;
    int c0;
    int c1;

    // reset and post-reset state
    rst_cmd = 1'b1;
    idle(3);
    rst_cmd = 1'b0;
    step();
    check("rst_busy",  fsm_busy,         1'b0);
    check("rst_en",    memory_enable,    1'b0);
    check("rst_addr",  memory_address,   16'h0000);
    check("rst_wr",    write_data_array, 1'b0);
    check("rst_idx",   cache_word_index, 3'd0);
    check("rst_tag",   write_tag_array,  1'b0);
    check("rst_done",  fill_done,        1'b0);
    idle(2);

    // basic fill, wrap/alignment, latency sweep
    single_fill("basic", 16'h1236, 4);
    single_fill("wrap",  16'hFFFF, 3);
    single_fill("lat1",  16'h0402, 1);
    single_fill("lat7",  16'h7778, 7);

    // reset in the fourth cycle of a fill, memory keeps answering
    lat = 4;
    t   = tags_seen;
    start_miss(16'h3456, 1, c0);
    idle(3);
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
    idle(15);
    check("rst_mid_tags", tags_seen - t, 0);
    single_fill("after_rst", 16'h3456, 4);

    // stray valids in IDLE, miss held through fill and the following IDLE
    spur_en = 1'b1;
    idle(10);
    t = tags_seen;
    start_miss(16'h0A10, 15, c0);
    idle(30);
    spur_en = 1'b0;
    check("spur_tags", tags_seen - t, 2);
    check("spur_done_cyc", last_tag_cyc - c0, 27);

    // back-to-back misses
    lat = 4;
    t   = tags_seen;
    start_miss(16'h0040, 1, c0);
    idle(13);
    start_miss(16'h2000, 1, c1);
    idle(20);
    check("b2b_tags", tags_seen - t, 2);
    check("b2b_gap", c1 - c0, 14);
    check("b2b_done_cyc", last_tag_cyc - c0, 27);

    // randomized fills
    for (int i = 0; i < 8; i++) begin
      spur_en = bit'($urandom_range(0, 1));
      single_fill("rand", 16'($urandom), int'($urandom_range(1, 7)));
      idle(int'($urandom_range(0, 3)));
    end
    spur_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
